// File: rtl/periferico_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with CTRL (SEND) and DATA registers.
// Software loads DATA, sets SEND; hardware clears SEND when the stop bit ends.
module periferico_uart_tx #(
    parameter int unsigned BAUD_DIV = 868
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_ctrl_i,
    input  logic        we_data_i,
    input  logic        reg_sel_i,
    input  logic [31:0] wr_data_i,
    output logic [31:0] rd_data_o,
    output logic        tx_o,
    output logic        busy_o
);

    localparam int unsigned CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned BIT_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(7);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             send_q, send_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             bit_end;

    // Upper store-data bits have no register behind them.
    logic unused_wr_bits;
    assign unused_wr_bits = ^wr_data_i[31:8];

    assign bit_end = (cnt_q == CNT_MAX);

    // State register and datapath flops; reset aborts any frame in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            send_q  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            send_q  <= send_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state, register writes and next line level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        send_d  = send_q;
        tx_d    = tx_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                tx_d  = 1'b1;
                // Registers are writable only while idle.
                if (we_data_i) begin
                    data_d = wr_data_i[7:0];
                end
                if (we_ctrl_i) begin
                    send_d = wr_data_i[0];
                end
                // Launch uses the values held before this edge's writes.
                if (send_q) begin
                    state_d = ST_START;
                    shift_d = data_q;
                    tx_d    = 1'b0;
                end
            end

            ST_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = bit_q + BIT_W'(1);
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    send_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Zero-latency register read path.
    always_comb begin
        rd_data_o = reg_sel_i ? {24'b0, data_q} : {31'b0, send_q};
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_periferico_uart_tx.sv
// Randomized and directed bench for periferico_uart_tx against a frame-level model.
module tb_periferico_uart_tx;

    localparam int unsigned BD = 4;
    localparam int unsigned FRAME = 10 * BD;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        we_ctrl_i;
    logic        we_data_i;
    logic        reg_sel_i;
    logic [31:0] wr_data_i;
    logic [31:0] rd_data_o;
    logic        tx_o;
    logic        busy_o;

    int n_vec = 0;
    int n_bad = 0;

    periferico_uart_tx #(.BAUD_DIV(BD)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_ctrl_i (we_ctrl_i),
        .we_data_i (we_data_i),
        .reg_sel_i (reg_sel_i),
        .wr_data_i (wr_data_i),
        .rd_data_o (rd_data_o),
        .tx_o      (tx_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: register contents plus "frame active, cycles elapsed, byte".
    logic       m_ok = 1'b0;
    logic       m_send;
    logic [7:0] m_data;
    logic       m_active;
    int         m_el;
    logic [7:0] m_byte;
    logic       m_go;
    logic [7:0] m_snap;

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_ok     = 1'b1;
            m_send   = 1'b0;
            m_data   = 8'h00;
            m_active = 1'b0;
            m_el     = 0;
        end else if (m_ok) begin
            if (m_active) begin
                m_el++;
                if (m_el == FRAME) begin
                    m_active = 1'b0;
                    m_send   = 1'b0;
                end
            end else begin
                m_go   = m_send;
                m_snap = m_data;
                if (we_data_i) m_data = wr_data_i[7:0];
                if (we_ctrl_i) m_send = wr_data_i[0];
                if (m_go) begin
                    m_active = 1'b1;
                    m_el     = 0;
                    m_byte   = m_snap;
                end
            end
        end
    end

    function automatic logic exp_tx();
        int slot;
        if (!m_active) return 1'b1;
        slot = m_el / BD;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return m_byte[slot-1];
    endfunction

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk_i) begin
        if (m_ok) begin
            chk("model_tx",   32'(tx_o),   32'(exp_tx()));
            chk("model_busy", 32'(busy_o), 32'(m_active));
            chk("model_rd",   rd_data_o,
                reg_sel_i ? {24'b0, m_data} : {31'b0, m_send});
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle_in();
        rst_i     = 1'b0;
        we_ctrl_i = 1'b0;
        we_data_i = 1'b0;
        wr_data_i = 32'h0;
    endtask

    task automatic wr_data(input logic [31:0] v);
        we_data_i = 1'b1;
        wr_data_i = v;
        tick();
        idle_in();
    endtask

    task automatic wr_ctrl(input logic [31:0] v);
        we_ctrl_i = 1'b1;
        wr_data_i = v;
        tick();
        idle_in();
    endtask

    int idx;
    int busy_cnt;

    initial begin
        rst_i     = 1'b1;
        we_ctrl_i = 1'b0;
        we_data_i = 1'b0;
        reg_sel_i = 1'b0;
        wr_data_i = 32'h0;
        tick();
        tick();
        idle_in();

        // 1: idle after reset
        repeat (20) begin
            tick();
            reg_sel_i = ~reg_sel_i;
        end
        @(negedge clk_i);
        chk("idle_tx", 32'(tx_o), 32'h1);
        chk("idle_busy", 32'(busy_o), 32'h0);
        chk("idle_rd_a", rd_data_o, 32'h0);
        tick();
        reg_sel_i = ~reg_sel_i;
        @(negedge clk_i);
        chk("idle_rd_b", rd_data_o, 32'h0);

        // 2: 0x55 frame, literal line pattern 0,1,0,1,... per bit slot
        tick();
        reg_sel_i = 1'b0;
        wr_data(32'h55);
        wr_ctrl(32'h1);
        idx = 0;
        busy_cnt = 0;
        repeat (FRAME + 6) begin
            tick();
            @(negedge clk_i);
            if (busy_o) begin
                busy_cnt++;
                if (idx % BD == 0) chk("f55_slot", 32'(tx_o), 32'((idx / BD) % 2));
                if (idx == 20) chk("f55_send_mid", rd_data_o, 32'h1);
                idx++;
            end
        end
        chk("f55_busy_len", 32'(busy_cnt), 32'(FRAME));
        chk("f55_send_after", rd_data_o, 32'h0);

        // 3: writes during a frame are ignored
        tick();
        wr_data(32'hA3);
        wr_ctrl(32'h1);
        repeat (10) tick();
        we_data_i = 1'b1;
        we_ctrl_i = 1'b1;
        wr_data_i = 32'hFF;
        reg_sel_i = 1'b1;
        tick();
        idle_in();
        @(negedge clk_i);
        chk("a3_data_kept", rd_data_o, 32'hA3);
        repeat (FRAME) tick();
        reg_sel_i = 1'b0;
        @(negedge clk_i);
        chk("a3_send_clr", rd_data_o, 32'h0);

        // 4: both strobes in one cycle, start bit one cycle later
        tick();
        we_data_i = 1'b1;
        we_ctrl_i = 1'b1;
        wr_data_i = 32'h0F;
        @(negedge clk_i);
        tick();
        idle_in();
        @(negedge clk_i);
        chk("both_pre_tx", 32'(tx_o), 32'h1);
        chk("both_pre_busy", 32'(busy_o), 32'h0);
        tick();
        @(negedge clk_i);
        chk("both_start_tx", 32'(tx_o), 32'h0);
        chk("both_start_busy", 32'(busy_o), 32'h1);
        repeat (FRAME + 2) tick();

        // 5: reset during data bit 3
        wr_data(32'h81);
        wr_ctrl(32'h1);
        repeat (18) tick();
        rst_i = 1'b1;
        tick();
        idle_in();
        @(negedge clk_i);
        chk("rst_tx", 32'(tx_o), 32'h1);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_send", rd_data_o, 32'h0);
        reg_sel_i = 1'b1;
        #1;
        chk("rst_data", rd_data_o, 32'h0);
        tick();
        reg_sel_i = 1'b0;
        wr_data(32'h81);
        wr_ctrl(32'h1);
        repeat (FRAME + 2) tick();

        // 6: upper store bits are dropped
        we_data_i = 1'b1;
        wr_data_i = 32'hFFFF_FF3C;
        tick();
        we_data_i = 1'b0;
        we_ctrl_i = 1'b1;
        wr_data_i = 32'hFFFF_FFFF;
        tick();
        idle_in();
        reg_sel_i = 1'b1;
        @(negedge clk_i);
        chk("mask_data", rd_data_o, 32'h0000_003C);
        tick();
        reg_sel_i = 1'b0;
        @(negedge clk_i);
        chk("mask_ctrl", rd_data_o, 32'h0000_0001);
        repeat (FRAME + 2) tick();

        // Randomized traffic checked by the model
        repeat (3000) begin
            rst_i     = ($urandom_range(0, 399) == 0);
            we_data_i = ($urandom_range(0, 5) == 0);
            we_ctrl_i = ($urandom_range(0, 7) == 0);
            wr_data_i = $urandom;
            reg_sel_i = 1'($urandom_range(0, 1));
            tick();
        end
        idle_in();
        repeat (FRAME + 2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
